interval_timer_ctrl: RTL and testbench
======================================

Name: interval_timer_ctrl

Overview:
- Controller that sequences a WIDTH-bit up-counter as a programmable interval timer: start/stop/pause control, prescaled ticks, one-shot or periodic expiry, and a sticky interrupt with overrun detection.
- Sits between the control/status register block and interrupt logic.
- Owns the counter datapath and exposes the live count for status readback.

Parameters:
- WIDTH, 8, counter and period width in bits.
- PRESC_WIDTH, 4, prescaler divider width in bits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  single-cycle pulse; latch config and (re)start timing.
- stop  in  1  single-cycle pulse; abort timing and return to idle.
- pause  in  1  level; freezes count and prescaler while high.
- mode  in  1  0 = one-shot, 1 = periodic; sampled only on start.
- period  in  WIDTH  terminal count; sampled only on start.
- presc_div  in  PRESC_WIDTH  tick every presc_div+1 cycles; sampled only on start.
- irq_ack  in  1  pulse; clears irq and overrun.
- count  out  WIDTH  current count.
- busy  out  1  high in RUN or PAUSED.
- expired  out  1  one-cycle pulse per expiry.
- irq  out  1  sticky expiry flag.
- overrun  out  1  sticky; expiry occurred while irq already set.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; count, prescaler, shadow regs = 0; all outputs 0.
- States: IDLE, RUN, PAUSED.
  - busy = (state != IDLE).
  - All outputs are registered.
- Control priority each cycle: stop > start > pause.
- IDLE:
  - count held at 0.
  - start → RUN: latch mode/period/presc_div into shadow regs; count=0; prescaler=0.
- RUN:
  - Prescaler increments each cycle.
  - tick = (prescaler == presc_div_q). On tick, prescaler resets to 0.
  - Tick with count != period_q: count += 1.
  - Tick with count == period_q (expiry):
    - count ← 0, expired=1 for the following cycle, irq ← 1.
    - Periodic stays in RUN; one-shot → IDLE.
  - Expiry interval = (period_q+1)*(presc_div_q+1) cycles.
  - period_q = 0 expires on every tick.
- Latency: start sampled at edge k, presc_div=0 → count=1 after edge k+1. First expiry registered at edge k+period+1.
- PAUSED:
  - RUN with pause=1 → PAUSED; count and prescaler frozen, no tick.
  - pause=0 → RUN, resuming from the frozen values.
- stop (RUN or PAUSED) → IDLE; count=0; no expired pulse. stop in IDLE is a no-op.
- start in RUN or PAUSED: restart, reloading shadow regs, count=0, prescaler=0. A pending tick in the same cycle is discarded.
- start and stop in the same cycle: stop wins → IDLE.
- Config inputs changed while busy are ignored until the next start.
- irq / overrun:
  - irq_ack clears both.
  - Expiry in the same cycle as irq_ack: irq stays 1, overrun unchanged (not set).
  - Expiry with irq=1 and no ack: overrun ← 1.
- Width rules: count is WIDTH bits and never exceeds period_q. An expiry at count=2^WIDTH-1 wraps to 0.

Decomposition:
- Shared package:
  - State enum: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2.
  - Mode constants: MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- One sub-module, timer_prescaler:
  - PRESC_WIDTH counter with div, enable (run & !pause) and clear inputs.
  - tick output; clears on start/stop.
- Counter, FSM and irq logic stay in the top.

Test Plan:
1. Reset: assert rst mid-simulation with count=100 → count, busy, expired, irq, overrun all 0 immediately (before the next clk edge); release, idle for 3 cycles → values unchanged.
2. One-shot, period=3, presc_div=0, start:
   - count goes 1,2,3,0 on successive cycles.
   - expired high exactly one cycle, coincident with count returning to 0.
   - busy falls in the same cycle; irq=1 held until irq_ack, then 0.
3. Periodic, period=4, presc_div=1: each count value is held 2 cycles; expired pulses exactly every 10 cycles for 3 expiries; busy stays 1; irq=1.
4. Overrun, periodic, period=0, presc_div=0, no ack:
   - expired high every cycle; irq=1; overrun=1 after the second expiry.
   - irq_ack pulse → overrun 0 the next cycle, irq stays 1 (simultaneous expiry).
5. Pause/restart, periodic, period=255:
   - pause high at count=10 for 5 cycles → count stays 10, busy=1; release → 11.
   - mid-run start with period=2 → count restarts at 0, expires at 2.
6. Stop priority: start and stop pulsed together while running at count=7 → next cycle state IDLE, count 0, busy 0, no expired; a following start alone resumes counting from 1.

Source files
------------

// File: rtl/interval_timer_ctrl_pkg.sv
// Interval timer controller: shared types.
// FSM state encoding and expiry mode constants.
package interval_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Interval timer controller: control/status bundle.
// master = register block side, slave = timer side.
interface interval_timer_ctrl_if #(
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 4
);
    logic                   start;
    logic                   stop;
    logic                   pause;
    logic                   mode;
    logic [WIDTH-1:0]       period;
    logic [PRESC_WIDTH-1:0] presc_div;
    logic                   irq_ack;
    logic [WIDTH-1:0]       count;
    logic                   busy;
    logic                   expired;
    logic                   irq;
    logic                   overrun;

    modport master (
        output start, stop, pause, mode, period, presc_div, irq_ack,
        input  count, busy, expired, irq, overrun
    );

    modport slave (
        input  start, stop, pause, mode, period, presc_div, irq_ack,
        output count, busy, expired, irq, overrun
    );
endinterface

// File: rtl/interval_timer_ctrl_prescaler.sv
// Interval timer controller: tick prescaler.
// Emits a tick every div+1 enabled cycles; clear restarts the phase.
module timer_prescaler #(
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [PRESC_WIDTH-1:0] div,
    output logic                   tick
);
    logic [PRESC_WIDTH-1:0] cnt;

    assign tick = enable && (cnt == div);

    // Divider phase: cleared on (re)start/stop, frozen when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: FSM, counter and sticky interrupt.
// Prescaled up-counter with one-shot/periodic expiry and overrun.
module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    interval_timer_ctrl_if.slave bus
);
    state_t                 state;
    state_t                 state_next;
    logic                   mode_q;
    logic [WIDTH-1:0]       period_q;
    logic [PRESC_WIDTH-1:0] div_q;
    logic [WIDTH-1:0]       count_q;
    logic                   expired_q;
    logic                   irq_q;
    logic                   overrun_q;
    logic                   restart;
    logic                   clear;
    logic                   run_en;
    logic                   tick;
    logic                   expiry;

    // stop beats start; either one discards any tick this cycle.
    assign restart = bus.start && !bus.stop;
    assign clear   = bus.start || bus.stop;
    assign run_en  = (state == RUN) && !bus.pause && !clear;
    assign expiry  = tick && (count_q == period_q);

    timer_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .enable(run_en),
        .div   (div_q),
        .tick  (tick)
    );

    // Shadow config, captured only on an effective start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_ONESHOT;
            period_q <= '0;
            div_q    <= '0;
        end else if (restart) begin
            mode_q   <= bus.mode;
            period_q <= bus.period;
            div_q    <= bus.presc_div;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: stop > start > pause > expiry.
    always_comb begin
        state_next = state;
        if (bus.stop) begin
            state_next = IDLE;
        end else if (bus.start) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (bus.pause) begin
                        state_next = PAUSED;
                    end else if (expiry && mode_q == MODE_ONESHOT) begin
                        state_next = IDLE;
                    end
                end
                PAUSED: begin
                    if (!bus.pause) begin
                        state_next = RUN;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Counter, expiry pulse and sticky irq/overrun flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            expired_q <= expiry;
            if (clear || expiry) begin
                count_q <= '0;
            end else if (tick) begin
                count_q <= count_q + 1'b1;
            end
            if (expiry) begin
                irq_q <= 1'b1;
            end else if (bus.irq_ack) begin
                irq_q <= 1'b0;
            end
            if (bus.irq_ack) begin
                overrun_q <= 1'b0;
            end else if (expiry && irq_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = (state != IDLE);
    assign bus.expired = expired_q;
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Testbench for interval_timer_ctrl: table vectors, directed
// corner sequences and random stimulus against an arithmetic model.
module tb_interval_timer_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    interval_timer_ctrl_if #(.WIDTH(8), .PRESC_WIDTH(4)) bus ();

    interval_timer_ctrl #(
        .WIDTH(8),
        .PRESC_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: timing is tracked as enabled cycles elapsed
    // since (re)start; count and expiry follow by division.
    logic m_run, m_pau, m_mode, m_irq, m_ovr, m_exp;
    int   m_el, m_per, m_dv;

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic       mode;
        logic       ack;
        logic [7:0] period;
        logic [3:0] div;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_exp;
        logic       e_irq;
        logic       e_ovr;
    } vec_t;

    vec_t tbl[8];

    task automatic model_reset();
        m_run = 1'b0; m_pau = 1'b0; m_mode = 1'b0;
        m_irq = 1'b0; m_ovr = 1'b0; m_exp = 1'b0;
        m_el = 0; m_per = 0; m_dv = 0;
    endtask

    task automatic model_step();
        logic ex;
        ex = 1'b0;
        if (bus.stop) begin
            m_run = 1'b0; m_pau = 1'b0; m_el = 0;
        end else if (bus.start) begin
            m_run = 1'b1; m_pau = 1'b0; m_el = 0;
            m_mode = bus.mode;
            m_per = int'(bus.period);
            m_dv = int'(bus.presc_div);
        end else if (m_run && !m_pau) begin
            if (bus.pause) begin
                m_pau = 1'b1;
            end else begin
                m_el++;
                if (m_el == (m_dv + 1) * (m_per + 1)) begin
                    ex = 1'b1;
                    m_el = 0;
                    if (!m_mode) m_run = 1'b0;
                end
            end
        end else if (m_run && !bus.pause) begin
            m_pau = 1'b0;
        end
        if (bus.irq_ack) m_ovr = 1'b0;
        else if (ex && m_irq) m_ovr = 1'b1;
        if (ex) m_irq = 1'b1;
        else if (bus.irq_ack) m_irq = 1'b0;
        m_exp = ex;
    endtask

    function automatic logic [7:0] m_count();
        int c;
        c = m_run ? (m_el / (m_dv + 1)) % (m_per + 1) : 0;
        return 8'(c);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Packed view {count,busy,expired,irq,overrun} vs. model.
    task automatic chk_model(input string nm);
        chk(nm, {20'd0, bus.count, bus.busy, bus.expired, bus.irq, bus.overrun},
            {20'd0, m_count(), m_run, m_exp, m_irq, m_ovr});
    endtask

    task automatic step(input string nm);
        model_step();
        @(posedge clk);
        #1;
        chk_model(nm);
    endtask

    task automatic idle_in();
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
        bus.irq_ack = 1'b0;
    endtask

    task automatic go(input logic md, input logic [7:0] per,
                      input logic [3:0] dv);
        bus.start = 1'b1; bus.mode = md;
        bus.period = per; bus.presc_div = dv;
        step("start");
        bus.start = 1'b0;
    endtask

    task automatic halt();
        bus.stop = 1'b1; bus.irq_ack = 1'b1;
        step("halt");
        bus.stop = 1'b0; bus.irq_ack = 1'b0;
    endtask

    initial begin
        int nexp;
        int last;
        int gap_bad;
        logic seen;
        n_cmp = 0;
        n_bad = 0;
        idle_in();
        bus.mode = 1'b0; bus.period = '0; bus.presc_div = '0;
        model_reset();

        // Test 2 vectors: one-shot, period 3, no prescale.
        tbl[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'd3,4'd0, 8'd0,1'b1,1'b0,1'b0,1'b0};
        tbl[1] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'd3,4'd0, 8'd1,1'b1,1'b0,1'b0,1'b0};
        tbl[2] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'd3,4'd0, 8'd2,1'b1,1'b0,1'b0,1'b0};
        tbl[3] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'd3,4'd0, 8'd3,1'b1,1'b0,1'b0,1'b0};
        tbl[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'd3,4'd0, 8'd0,1'b0,1'b1,1'b1,1'b0};
        tbl[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'd3,4'd0, 8'd0,1'b0,1'b0,1'b1,1'b0};
        tbl[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'd3,4'd0, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'd3,4'd0, 8'd0,1'b0,1'b0,1'b0,1'b0};

        // Power-on reset.
        rst = 1'b1;
        #12;
        chk_model("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: asynchronous reset from count=100.
        go(1'b1, 8'd200, 4'd0);
        for (int i = 0; i < 100; i++) step("t1_run");
        chk("t1_count100", {24'd0, bus.count}, 32'd100);
        #1;
        rst = 1'b1;
        #1;
        chk("t1_async", {27'd0, bus.count == 8'd0, bus.busy, bus.expired,
                         bus.irq, bus.overrun}, 32'h10);
        model_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("t1_idle");
            chk("t1_idle_zero", {24'd0, bus.count} | {31'd0, bus.busy}, 32'd0);
        end

        // Test 2: table-driven one-shot.
        for (int i = 0; i < 8; i++) begin
            bus.start = tbl[i].start; bus.stop = tbl[i].stop;
            bus.pause = tbl[i].pause; bus.mode = tbl[i].mode;
            bus.irq_ack = tbl[i].ack; bus.period = tbl[i].period;
            bus.presc_div = tbl[i].div;
            step("t2_model");
            chk($sformatf("t2_row%0d", i),
                {20'd0, bus.count, bus.busy, bus.expired, bus.irq, bus.overrun},
                {20'd0, tbl[i].e_count, tbl[i].e_busy, tbl[i].e_exp,
                 tbl[i].e_irq, tbl[i].e_ovr});
        end
        idle_in();

        // Test 3: periodic, period 4, divide by 2.
        go(1'b1, 8'd4, 4'd1);
        nexp = 0; last = 0; gap_bad = 0;
        for (int j = 1; j <= 30; j++) begin
            step("t3_run");
            if (bus.expired) begin
                if (j - last != 10) gap_bad++;
                last = j;
                nexp++;
            end
        end
        chk("t3_nexp", nexp, 3);
        chk("t3_gap", gap_bad, 0);
        chk("t3_busy_irq", {30'd0, bus.busy, bus.irq}, 32'd3);
        halt();

        // Test 4: overrun with period 0.
        go(1'b1, 8'd0, 4'd0);
        step("t4_e1");
        chk("t4_first", {29'd0, bus.expired, bus.irq, bus.overrun}, 32'b110);
        step("t4_e2");
        chk("t4_second", {29'd0, bus.expired, bus.irq, bus.overrun}, 32'b111);
        bus.irq_ack = 1'b1;
        step("t4_ack");
        bus.irq_ack = 1'b0;
        chk("t4_ack_ovr", {30'd0, bus.irq, bus.overrun}, 32'b10);
        halt();

        // Test 5: pause, resume and mid-run restart.
        go(1'b1, 8'd255, 4'd0);
        for (int i = 0; i < 10; i++) step("t5_run");
        chk("t5_count10", {24'd0, bus.count}, 32'd10);
        bus.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("t5_pause");
            chk("t5_frozen", {23'd0, bus.count, bus.busy}, {23'd0, 8'd10, 1'b1});
        end
        bus.pause = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            step("t5_resume");
            if (bus.count == 8'd11) seen = 1'b1;
        end
        chk("t5_resume11", {31'd0, seen}, 32'd1);
        go(1'b1, 8'd2, 4'd0);
        chk("t5_restart0", {24'd0, bus.count}, 32'd0);
        step("t5_r1");
        step("t5_r2");
        chk("t5_at2", {24'd0, bus.count}, 32'd2);
        step("t5_r3");
        chk("t5_expire", {23'd0, bus.count, bus.expired}, 32'd1);
        halt();

        // Test 6: start and stop together.
        go(1'b1, 8'd50, 4'd0);
        for (int i = 0; i < 7; i++) step("t6_run");
        chk("t6_count7", {24'd0, bus.count}, 32'd7);
        bus.start = 1'b1; bus.stop = 1'b1;
        step("t6_both");
        bus.stop = 1'b0;
        chk("t6_stopwins", {22'd0, bus.count, bus.busy, bus.expired}, 32'd0);
        step("t6_restart");
        bus.start = 1'b0;
        step("t6_count");
        chk("t6_count1", {23'd0, bus.count, bus.busy}, {23'd0, 8'd1, 1'b1});
        halt();

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(0, 29) == 0);
            bus.stop = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 14) == 0) bus.pause = ~bus.pause;
            bus.irq_ack = ($urandom_range(0, 11) == 0);
            bus.mode = 1'($urandom_range(0, 1));
            bus.period = ($urandom_range(0, 7) == 0) ?
                         8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
            bus.presc_div = 4'($urandom_range(0, 3));
            step("rand");
        end
        idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
